// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART transmit arbiter.
package uart_pkg;

  localparam int unsigned UART_DW          = 8;
  localparam int unsigned UART_TIMEOUT_DEF = 4096;
  localparam int unsigned ID_W             = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SEND = 2'd1;
  localparam state_t ST_ACK  = 2'd2;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping modulo NREQ.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_last,
  output logic            o_valid,
  output logic [ID_W-1:0] o_idx
);

  logic [ID_W-1:0] w_cand;

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_cand = ID_W'((32'(i_last) + k) % NREQ);
      if (!o_valid && (|(i_req & (NREQ'(1) << w_cand)))) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding one UART transmitter from NREQ byte requesters.
// Optional SEND abort timer enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TIMEOUT_CYC = UART_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [8*NREQ-1:0]    req_data,
  output logic [NREQ-1:0]      ack,
  output logic [UART_DW-1:0]   uart_din,
  output logic                 uart_send,
  input  logic                 uart_done,
  output logic                 busy,
  output logic [ID_W-1:0]      cur_id,
  output logic                 timeout_err
);

  state_t              r_state,  w_state_nxt;
  logic                r_send,   w_send_nxt;
  logic [UART_DW-1:0]  r_din,    w_din_nxt;
  logic [ID_W-1:0]     r_cur_id, w_cur_nxt;
  logic [ID_W-1:0]     r_last,   w_last_nxt;
  logic [NREQ-1:0]     r_ack,    w_ack_nxt;
  logic                r_busy;
  logic                r_terr,   w_terr_nxt;
  logic [NREQ-1:0]     w_req_m;
  logic                w_pick_valid;
  logic [ID_W-1:0]     w_pick_idx;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TCW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TCW-1:0] r_tcnt, w_tcnt_nxt;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^32'(TIMEOUT_CYC);
`endif

  // The just-acked requester has not yet seen ack during ACK, so it sits out that cycle's pick.
  always_comb begin
    w_req_m = req;
    if (r_state == ST_ACK) w_req_m = req & ~(NREQ'(1) << r_cur_id);
  end

  uart_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req   (w_req_m),
    .i_last  (r_last),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_send_nxt  = r_send;
    w_din_nxt   = r_din;
    w_cur_nxt   = r_cur_id;
    w_last_nxt  = r_last;
    w_ack_nxt   = '0;
    w_terr_nxt  = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    w_tcnt_nxt  = r_tcnt;
`endif
    case (r_state)
      ST_IDLE, ST_ACK: begin
        // Granting straight out of ACK keeps uart_send low for just one cycle.
        if (w_pick_valid) begin
          w_state_nxt = ST_SEND;
          w_send_nxt  = 1'b1;
          w_din_nxt   = UART_DW'(req_data >> (32'(w_pick_idx) * UART_DW));
          w_cur_nxt   = w_pick_idx;
          w_last_nxt  = w_pick_idx;
`ifdef UART_ARB_TIMEOUT_EN
          w_tcnt_nxt  = '0;
`endif
        end else begin
          w_state_nxt = ST_IDLE;
          w_send_nxt  = 1'b0;
        end
      end
      ST_SEND: begin
        if (uart_done) begin
          w_state_nxt = ST_ACK;
          w_send_nxt  = 1'b0;
          w_ack_nxt   = NREQ'(1) << r_cur_id;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (r_tcnt == TCW'(TIMEOUT_CYC - 1)) begin
          w_state_nxt = ST_ACK;
          w_send_nxt  = 1'b0;
          w_ack_nxt   = NREQ'(1) << r_cur_id;
          w_terr_nxt  = 1'b1;
        end else begin
          w_tcnt_nxt  = r_tcnt + TCW'(1);
        end
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_send_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_send   <= 1'b0;
      r_din    <= '0;
      r_cur_id <= '0;
      r_last   <= ID_W'(NREQ - 1);
      r_ack    <= '0;
      r_busy   <= 1'b0;
      r_terr   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      r_tcnt   <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_send   <= w_send_nxt;
      r_din    <= w_din_nxt;
      r_cur_id <= w_cur_nxt;
      r_last   <= w_last_nxt;
      r_ack    <= w_ack_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_terr   <= w_terr_nxt;
`ifdef UART_ARB_TIMEOUT_EN
      r_tcnt   <= w_tcnt_nxt;
`endif
    end
  end

  assign ack         = r_ack;
  assign uart_din    = r_din;
  assign uart_send   = r_send;
  assign busy        = r_busy;
  assign cur_id      = r_cur_id;
  assign timeout_err = r_terr;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb (NREQ=4, TIMEOUT_CYC=16).
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [7:0]  uart_din;
  logic        uart_send;
  logic        uart_done;
  logic        busy;
  logic [2:0]  cur_id;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  uart_tx_arb #(.NREQ(4), .TIMEOUT_CYC(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .uart_din    (uart_din),
    .uart_send   (uart_send),
    .uart_done   (uart_done),
    .busy        (busy),
    .cur_id      (cur_id),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_done();
    uart_done = 1'b1;
    tick();
    uart_done = 1'b0;
  endtask

  initial begin
    logic [2:0] exp_id;
    reset = 1'b1; req = '0; req_data = '0; uart_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_send", 32'(uart_send), 32'd0);
    chk("rst_din",  32'(uart_din),  32'd0);
    chk("rst_ack",  32'(ack),       32'd0);
    chk("rst_busy", 32'(busy),      32'd0);
    chk("rst_cur",  32'(cur_id),    32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);

    // done while idle is ignored
    pulse_done();
    chk("idle_done_ack",  32'(ack),  32'd0);
    chk("idle_done_busy", 32'(busy), 32'd0);

    // single request
    req_data = 32'h000000A5; req = 4'b0001;
    tick();
    chk("single_send", 32'(uart_send), 32'd1);
    chk("single_din",  32'(uart_din),  32'hA5);
    chk("single_cur",  32'(cur_id),    32'd0);
    chk("single_busy", 32'(busy),      32'd1);
    tick(); tick();
    chk("single_hold", 32'(uart_send), 32'd1);
    pulse_done();
    chk("single_ack",   32'(ack),       32'b0001);
    chk("single_low",   32'(uart_send), 32'd0);
    chk("single_abusy", 32'(busy),      32'd1);
    req = '0;
    tick();
    chk("single_ack_end", 32'(ack),  32'd0);
    chk("single_idle",    32'(busy), 32'd0);

    // fairness from reset: 0,1,2,3,0,1,2,3
    reset = 1'b1; tick(); reset = 1'b0;
    req_data = 32'h13121110; req = 4'b1111;
    tick();
    for (int n = 0; n < 8; n++) begin
      exp_id = 3'(n % 4);
      chk("fair_cur",  32'(cur_id),    32'(exp_id));
      chk("fair_din",  32'(uart_din),  32'h10 + 32'(exp_id));
      chk("fair_send", 32'(uart_send), 32'd1);
      tick();
      pulse_done();
      chk("fair_ack",    32'(ack),          32'(4'b0001 << exp_id));
      chk("fair_onehot", 32'($onehot0(ack)), 32'd1);
      tick();
    end
    req = '0;
    pulse_done();
    tick();
    chk("fair_idle", 32'(busy), 32'd0);

    // back-to-back: one low cycle, second byte from requester 1
    reset = 1'b1; tick(); reset = 1'b0;
    req_data = 32'h0000C35A; req = 4'b0011;
    tick();
    chk("b2b_din0", 32'(uart_din), 32'h5A);
    pulse_done();
    chk("b2b_low",  32'(uart_send), 32'd0);
    chk("b2b_ack0", 32'(ack),       32'b0001);
    req = 4'b0010;
    tick();
    chk("b2b_high", 32'(uart_send), 32'd1);
    chk("b2b_din1", 32'(uart_din),  32'hC3);
    chk("b2b_cur1", 32'(cur_id),    32'd1);
    pulse_done();
    chk("b2b_ack1", 32'(ack), 32'b0010);
    req = '0;
    tick();

    // requester 2 drops mid-SEND
    req_data = 32'h00770000; req = 4'b0100;
    tick();
    chk("drop_cur", 32'(cur_id), 32'd2);
    chk("drop_din", 32'(uart_din), 32'h77);
    req = '0;
    tick(); tick();
    chk("drop_send", 32'(uart_send), 32'd1);
    chk("drop_busy", 32'(busy),      32'd1);
    pulse_done();
    chk("drop_ack", 32'(ack), 32'b0100);
    tick();
    chk("drop_idle", 32'(busy), 32'd0);

    // reset mid-SEND with last grant = 1
    req_data = 32'h00004400; req = 4'b0010;
    tick();
    chk("rsend_cur", 32'(cur_id), 32'd1);
    req = '0;
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rsend_send", 32'(uart_send), 32'd0);
    chk("rsend_busy", 32'(busy),      32'd0);
    chk("rsend_ack",  32'(ack),       32'd0);
    pulse_done();
    chk("rsend_noack", 32'(ack), 32'd0);
    req_data = 32'h00332211; req = 4'b0111;
    tick();
    chk("rsend_next0", 32'(cur_id),   32'd0);
    chk("rsend_din",   32'(uart_din), 32'h11);
    req = '0;
    pulse_done();
    tick();

    // done withheld
    req_data = 32'h000000E7; req = 4'b0001;
    tick();
    chk("to_send", 32'(uart_send), 32'd1);
`ifdef UART_ARB_TIMEOUT_EN
    for (int c = 0; c < 15; c++) tick();
    chk("to_pre_send", 32'(uart_send),   32'd1);
    chk("to_pre_terr", 32'(timeout_err), 32'd0);
    tick();
    chk("to_terr", 32'(timeout_err), 32'd1);
    chk("to_ack",  32'(ack),         32'b0001);
    chk("to_low",  32'(uart_send),   32'd0);
    req = '0;
    tick();
    chk("to_terr_end", 32'(timeout_err), 32'd0);
    chk("to_ack_end",  32'(ack),         32'd0);
`else
    for (int c = 0; c < 20; c++) tick();
    chk("nto_busy", 32'(busy),        32'd1);
    chk("nto_send", 32'(uart_send),   32'd1);
    chk("nto_terr", 32'(timeout_err), 32'd0);
    chk("nto_ack",  32'(ack),         32'd0);
    req = '0;
    pulse_done();
    chk("nto_done_ack", 32'(ack), 32'b0001);
    tick();
`endif
    chk("final_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter TIMEOUT_CYC, default 4096: clk cycles allowed in SEND before abort; used only when UART_ARB_TIMEOUT_EN is defined.
REQ-003 clk  in  1  clock; all logic on posedge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 req  in  NREQ  per-requester transmit request, level; held with data until ack.
REQ-006 req_data  in  8*NREQ  byte for requester i in bits [8i+7:8i].
REQ-007 ack  out  NREQ  one-cycle pulse: requester i's byte completed or aborted.
REQ-008 uart_din  out  8  byte to UART transmitter, same bit order as the UART din port.
REQ-009 uart_send  out  1  raise-and-hold transmit request to UART.
REQ-010 uart_done  in  1  UART single-cycle completion pulse.
REQ-011 busy  out  1  high in any state other than IDLE.
REQ-012 cur_id  out  3  index of the granted requester, valid while busy.
REQ-013 timeout_err  out  1  one-cycle pulse on SEND abort.

Function
REQ-014 FSM states: IDLE, SEND, ACK; all outputs registered.
REQ-015 IDLE: if any req bit high, select a winner round-robin, latch its req_data into uart_din and the winner into cur_id, set uart_send=1, go to SEND; otherwise stay.
REQ-016 Latency: req sampled high at edge k -> uart_send high from cycle k+1.
REQ-017 Round-robin: search starts at last_grant+1 modulo NREQ; last_grant updates on each grant; after reset last_grant=NREQ-1, so requester 0 wins first.
REQ-018 SEND: hold uart_send=1 and uart_din constant; on uart_done go to ACK with uart_send=0.
REQ-019 ACK: lasts exactly one cycle; ack[cur_id]=1 that cycle only; uart_send=0; then IDLE.
REQ-020 Minimum uart_send low time between bytes: one cycle (the ACK cycle); back-to-back grant raises uart_send at done+2.
REQ-021 req[i] dropping during SEND does not abort; the byte completes and ack[i] still pulses.
REQ-022 uart_done in IDLE or ACK is ignored.
REQ-023 req[cur_id] still high in IDLE after ack counts as a new request and is arbitrated normally; other pending requesters win first.
REQ-024 ack is one-hot or zero in every cycle.

Reset
REQ-025 Reset to IDLE; uart_send=0, uart_din=0, ack=0, busy=0, cur_id=0, timeout_err=0, last_grant=NREQ-1, timeout counter=0.
REQ-026 Reset mid-SEND: uart_send low the cycle after the reset edge; no ack is issued for the aborted byte.

Configuration
REQ-027 Macro UART_ARB_TIMEOUT_EN defined: a counter clears on entry to SEND and increments each SEND cycle; when it reaches TIMEOUT_CYC-1 without uart_done, go to ACK, pulse timeout_err and ack[cur_id] together.
REQ-028 UART_ARB_TIMEOUT_EN undefined: no counter; SEND waits indefinitely; timeout_err tied 0.

Structure
REQ-029 Shared package uart_pkg holds the FSM state typedef, the UART byte width constant (8) and the default TIMEOUT_CYC.
REQ-030 Sub-module uart_rr_pick: combinational round-robin winner selection from req and last_grant, outputs valid and index.

Verification
REQ-031 Single: req=0001, data0=8'hA5 -> uart_send high next cycle, uart_din=A5; done pulse -> ack=0001 next cycle, uart_send low.
REQ-032 Fairness: req=1111 held through 8 bytes -> grant order 0,1,2,3,0,1,2,3; each ack one-hot.
REQ-033 Back-to-back: req=0011 -> uart_send low exactly one cycle between bytes; second uart_din=data1.
REQ-034 Drop: req[2] falls mid-SEND -> byte completes, ack=0100 on done+1.
REQ-035 Reset mid-SEND -> uart_send=0, busy=0 next cycle, no ack; next grant goes to requester 0.
REQ-036 With UART_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, done withheld -> timeout_err and ack[cur_id] pulse after 16 cycles in SEND; without it, busy stays high.
